// File: rtl/psum_acc_ctrl_if.sv
// -----------------------------------------------------------------------------
// psum_acc_ctrl_if
// Purpose : groups the drain-control, OFIFO, host-read and SRAM signals of
//           psum_acc_ctrl into a single bundle.
// Signals : start/acc_mode/base_addr/num_words/busy/done  - drain control
//           ofifo_valid/ofifo_data/ofifo_rd               - OFIFO head + pop
//           rd_req/rd_addr/rd_ready/rd_valid/rd_data      - host read port
//           mem_cen/mem_wen/mem_addr/mem_din/mem_dout     - SRAM port (active-low)
// Modports: slave  - controller side
//           master - environment side (host, OFIFO, SRAM)
// -----------------------------------------------------------------------------
interface psum_acc_ctrl_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 11,
    parameter int cnt_w   = 12
);
    logic                     start;
    logic                     acc_mode;
    logic [addr_w-1:0]        base_addr;
    logic [cnt_w-1:0]         num_words;
    logic                     busy;
    logic                     done;

    logic                     ofifo_valid;
    logic [col*psum_bw-1:0]   ofifo_data;
    logic                     ofifo_rd;

    logic                     rd_req;
    logic [addr_w-1:0]        rd_addr;
    logic                     rd_ready;
    logic                     rd_valid;
    logic [col*psum_bw-1:0]   rd_data;

    logic                     mem_cen;
    logic                     mem_wen;
    logic [addr_w-1:0]        mem_addr;
    logic [col*psum_bw-1:0]   mem_din;
    logic [col*psum_bw-1:0]   mem_dout;

    modport slave (
        input  start, acc_mode, base_addr, num_words,
        output busy, done,
        input  ofifo_valid, ofifo_data,
        output ofifo_rd,
        input  rd_req, rd_addr,
        output rd_ready, rd_valid, rd_data,
        output mem_cen, mem_wen, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output start, acc_mode, base_addr, num_words,
        input  busy, done,
        output ofifo_valid, ofifo_data,
        input  ofifo_rd,
        output rd_req, rd_addr,
        input  rd_ready, rd_valid, rd_data,
        input  mem_cen, mem_wen, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/psum_acc_ctrl.sv
// -----------------------------------------------------------------------------
// psum_acc_ctrl
// Purpose : drains a programmed number of psum words from the OFIFO into the
//           psum SRAM at an auto-incrementing (wrapping) address, either
//           overwriting or accumulating (read-modify-write, per-lane signed add)
//           onto the stored words. Idle cycles are lent to a host read port.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous active-low reset
//           bus   - psum_acc_ctrl_if.slave (control, OFIFO, host read, SRAM)
// Config  : PSUM_ACC_SAT_EN - when defined, accumulate results saturate per
//           lane; otherwise they wrap modulo 2^psum_bw.
// -----------------------------------------------------------------------------
module psum_acc_ctrl #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 11,
    parameter int cnt_w   = 12
) (
    input  logic           clk,
    input  logic           reset,
    psum_acc_ctrl_if.slave bus
);
    localparam int W = col * psum_bw;
    localparam logic [cnt_w-1:0]  CNT_ONE = 1;
    localparam logic [addr_w-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {IDLE, POP, WB, DONE} state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_acc;
    logic [cnt_w-1:0]  r_num;
    logic [cnt_w-1:0]  r_cnt;
    logic [addr_w-1:0] r_ptr;
    logic [W-1:0]      r_hold;
    logic              r_rd_valid;
    logic [W-1:0]      r_rd_data;

    logic              w_load;
    logic              w_hold;
    logic              w_adv;
    logic              w_last;
    logic              w_rd_ready;
    logic              w_grant;
    logic [W-1:0]      w_sum;

    assign w_last     = (r_cnt + CNT_ONE) == r_num;
    // Gated by reset so the grant indication is low while held in reset.
    assign w_rd_ready = reset && (r_state == IDLE) && !bus.start;
    assign w_grant    = w_rd_ready && bus.rd_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        w_hold       = 1'b0;
        w_adv        = 1'b0;
        bus.ofifo_rd = 1'b0;
        bus.mem_cen  = 1'b1;
        bus.mem_wen  = 1'b1;
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load = 1'b1;
                    w_next = (bus.num_words == '0) ? DONE : POP;
                end else if (w_grant) begin
                    bus.mem_cen  = 1'b0;
                    bus.mem_addr = bus.rd_addr;
                end
            end
            POP: begin
                if (bus.ofifo_valid) begin
                    bus.ofifo_rd = 1'b1;
                    bus.mem_cen  = 1'b0;
                    bus.mem_addr = r_ptr;
                    if (r_acc) begin
                        // Read the stored word now; it returns during WB.
                        w_hold = 1'b1;
                        w_next = WB;
                    end else begin
                        bus.mem_wen = 1'b0;
                        bus.mem_din = bus.ofifo_data;
                        w_adv       = 1'b1;
                        if (w_last) w_next = DONE;
                    end
                end
            end
            WB: begin
                bus.mem_cen  = 1'b0;
                bus.mem_wen  = 1'b0;
                bus.mem_addr = r_ptr;
                bus.mem_din  = w_sum;
                w_adv        = 1'b1;
                w_next       = w_last ? DONE : POP;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Per-lane signed add with one guard bit; lanes never carry into each other.
    always_comb begin : p_lane_sum
        logic [psum_bw:0] v;
        v     = '0;
        w_sum = '0;
        for (int unsigned i = 0; i < col; i++) begin
            v = {bus.mem_dout[i*psum_bw + psum_bw - 1], bus.mem_dout[i*psum_bw +: psum_bw]}
              + {r_hold[i*psum_bw + psum_bw - 1], r_hold[i*psum_bw +: psum_bw]};
`ifdef PSUM_ACC_SAT_EN
            // Guard bit disagreeing with the lane MSB means overflow; clamp by sign.
            if (v[psum_bw] != v[psum_bw-1])
                w_sum[i*psum_bw +: psum_bw] = v[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                                         : {1'b0, {(psum_bw-1){1'b1}}};
            else
                w_sum[i*psum_bw +: psum_bw] = v[psum_bw-1:0];
`else
            w_sum[i*psum_bw +: psum_bw] = v[psum_bw-1:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc      <= 1'b0;
            r_num      <= '0;
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_hold     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (w_load) begin
                r_acc <= bus.acc_mode;
                r_num <= bus.num_words;
                r_ptr <= bus.base_addr;
                r_cnt <= '0;
            end
            if (w_hold) r_hold <= bus.ofifo_data;
            if (w_adv) begin
                r_ptr <= r_ptr + PTR_ONE;
                r_cnt <= r_cnt + CNT_ONE;
            end
            r_rd_valid <= w_grant;
            if (r_rd_valid) r_rd_data <= bus.mem_dout;
        end
    end

    assign bus.busy     = (r_state == POP) || (r_state == WB);
    assign bus.done     = (r_state == DONE);
    assign bus.rd_ready = w_rd_ready;
    assign bus.rd_valid = r_rd_valid;
    // SRAM data is presented straight through in the valid cycle and captured
    // for holding afterwards, giving exactly one cycle grant-to-data.
    assign bus.rd_data  = r_rd_valid ? bus.mem_dout : r_rd_data;
endmodule

// File: tb/tb_psum_acc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_psum_acc_ctrl
// Purpose : self-checking bench for psum_acc_ctrl with a behavioural SRAM
//           (1-cycle read latency) and a show-ahead OFIFO model.
// Config  : expected saturation results follow PSUM_ACC_SAT_EN.
// -----------------------------------------------------------------------------
module tb_psum_acc_ctrl;
    localparam int COL = 8;
    localparam int PBW = 16;
    localparam int AW  = 11;
    localparam int CW  = 12;
    localparam int W   = COL * PBW;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    psum_acc_ctrl_if #(.col(COL), .psum_bw(PBW), .addr_w(AW), .cnt_w(CW)) bus();

    psum_acc_ctrl #(.col(COL), .psum_bw(PBW), .addr_w(AW), .cnt_w(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // SRAM model
    logic [W-1:0] sram [0:(1<<AW)-1];
    logic [W-1:0] sram_q = '0;
    always @(posedge clk) begin
        if (!bus.mem_cen) begin
            if (!bus.mem_wen) sram[bus.mem_addr] <= bus.mem_din;
            else              sram_q <= sram[bus.mem_addr];
        end
    end
    assign bus.mem_dout = sram_q;

    // OFIFO model: fhead owned by the pop process, ftail/fq by the stimulus.
    logic [W-1:0] fq [0:15];
    int unsigned  fhead = 0;
    int unsigned  ftail = 0;
    logic         fifo_en = 1'b0;
    assign bus.ofifo_valid = fifo_en && (fhead != ftail);
    assign bus.ofifo_data  = fq[fhead[3:0]];
    always @(posedge clk) if (bus.ofifo_rd && bus.ofifo_valid) fhead <= fhead + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [15:0] v, input logic [15:0] linc);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < COL; i++) w[i*PBW +: PBW] = v + 16'(i) * linc;
        return w;
    endfunction

    task automatic push(input logic [W-1:0] d);
        fq[ftail[3:0]] = d;
        ftail = ftail + 1;
    endtask

    task automatic run_drain(input logic acc, input logic [AW-1:0] base, input int num,
                             input logic [15:0] lane0, input logic [15:0] step,
                             input logic [15:0] linc, output int lat, output int writes);
        for (int k = 0; k < num; k++) push(mk(lane0 + 16'(k) * step, linc));
        fifo_en = 1'b1;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.acc_mode  = acc;
        bus.base_addr = base;
        bus.num_words = CW'(num);
        lat    = -1;
        writes = 0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (!bus.mem_cen && !bus.mem_wen) writes++;
            @(negedge clk);
        end
    endtask

    task automatic host_read(input logic [AW-1:0] a, output logic rdy, output logic vld,
                             output logic [W-1:0] d);
        @(negedge clk);
        bus.rd_req  = 1'b1;
        bus.rd_addr = a;
        #1 rdy = bus.rd_ready;
        @(negedge clk);
        bus.rd_req = 1'b0;
        #1;
        vld = bus.rd_valid;
        d   = bus.rd_data;
    endtask

    typedef struct {
        logic        acc;
        logic [AW-1:0] base;
        int          num;
        logic [15:0] lane0;
        logic [15:0] step;
        logic [15:0] linc;
        int          exp_lat;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
        logic [15:0] exp_linc;
    } vec_t;

    localparam int NV = 9;
    vec_t vt [NV];

    logic [15:0] sat_exp;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, wr, dones;
        logic rdy, vld;
        logic [W-1:0] d;
        logic [AW-1:0] last_a;

`ifdef PSUM_ACC_SAT_EN
        sat_exp = 16'h7FFF;
`else
        sat_exp = 16'h8004;
`endif
        //          acc   base      num lane0     step   linc  lat first     last      elinc
        vt[0] = '{1'b0, 11'd10,   4, 16'd1,     16'd1, 16'd1, 5, 16'd1,     16'd4,    16'd1};
        vt[1] = '{1'b0, 11'd100,  3, 16'd100,   16'd0, 16'd0, 4, 16'd100,   16'd100,  16'd0};
        vt[2] = '{1'b1, 11'd100,  3, 16'hFFE2,  16'd0, 16'd1, 7, 16'd70,    16'd70,   16'd1};
        vt[3] = '{1'b0, 11'd2047, 2, 16'd7,     16'd1, 16'd0, 3, 16'd7,     16'd8,    16'd0};
        vt[4] = '{1'b1, 11'd2047, 2, 16'hFFF8,  16'd0, 16'd0, 5, 16'hFFFF,  16'd0,    16'd0};
        vt[5] = '{1'b0, 11'd300,  0, 16'd0,     16'd0, 16'd0, 1, 16'd0,     16'd0,    16'd0};
        vt[6] = '{1'b0, 11'd200,  1, 16'd32767, 16'd0, 16'd0, 2, 16'd32767, 16'd32767,16'd0};
        vt[7] = '{1'b1, 11'd200,  1, 16'd5,     16'd0, 16'd0, 3, sat_exp,   sat_exp,  16'd0};
        vt[8] = '{1'b0, 11'd500,  4, 16'd9,     16'd0, 16'd0, 5, 16'd9,     16'd9,    16'd0};

        bus.start = 1'b0; bus.acc_mode = 1'b0; bus.base_addr = '0; bus.num_words = '0;
        bus.rd_req = 1'b1; bus.rd_addr = '0;

        // Reset values (rd_req held high to show rd_ready stays low in reset)
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst ctrl", {bus.busy, bus.done, bus.ofifo_rd, bus.rd_ready, bus.rd_valid,
                         bus.mem_cen, bus.mem_wen}, 7'b0000011);
        chk("rst mem_addr", bus.mem_addr, '0);
        chk("rst mem_din", bus.mem_din, '0);
        chk("rst rd_data", bus.rd_data, '0);
        @(negedge clk);
        bus.rd_req = 1'b0;
        reset = 1'b1;

        // Table-driven drains with host read-back
        for (int v = 0; v < NV; v++) begin
            run_drain(vt[v].acc, vt[v].base, vt[v].num, vt[v].lane0, vt[v].step,
                      vt[v].linc, lat, wr);
            chk($sformatf("v%0d latency", v), lat, vt[v].exp_lat);
            chk($sformatf("v%0d writes", v), wr, vt[v].num);
            if (vt[v].num > 0) begin
                host_read(vt[v].base, rdy, vld, d);
                chk($sformatf("v%0d first word", v), {rdy, vld, d},
                    {1'b1, 1'b1, mk(vt[v].exp_first, vt[v].exp_linc)});
                last_a = AW'(vt[v].base + AW'(vt[v].num - 1));
                host_read(last_a, rdy, vld, d);
                chk($sformatf("v%0d last word", v), {rdy, vld, d},
                    {1'b1, 1'b1, mk(vt[v].exp_last, vt[v].exp_linc)});
            end
        end

        // Wrap with a 3-cycle OFIFO stall between the two words
        push(mk(16'd11, 16'd0));
        push(mk(16'd12, 16'd0));
        fifo_en = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.acc_mode = 1'b0; bus.base_addr = 11'd2047; bus.num_words = 12'd2;
        @(negedge clk);
        bus.start = 1'b0;
        #1 chk("stall w1", {bus.mem_cen, bus.mem_wen, bus.mem_addr}, {1'b0, 1'b0, 11'd2047});
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            fifo_en = 1'b0;
            #1 chk($sformatf("stall idle %0d", s),
                   {bus.mem_cen, bus.ofifo_rd, bus.busy, bus.done}, 4'b1010);
        end
        @(negedge clk);
        fifo_en = 1'b1;
        #1 chk("stall w2", {bus.mem_cen, bus.mem_wen, bus.mem_addr, bus.mem_din},
               {1'b0, 1'b0, 11'd0, mk(16'd12, 16'd0)});
        @(negedge clk);
        #1 chk("stall done", bus.done, 1'b1);
        host_read(11'd2047, rdy, vld, d);
        chk("stall rd 2047", {rdy, vld, d}, {1'b1, 1'b1, mk(16'd11, 16'd0)});
        host_read(11'd0, rdy, vld, d);
        chk("stall rd 0", {rdy, vld, d}, {1'b1, 1'b1, mk(16'd12, 16'd0)});

        // Arbitration: start beats rd_req; rd_req blocked while busy; held request served after
        for (int k = 0; k < 3; k++) push(mk(16'd40, 16'd0));
        @(negedge clk);
        bus.start = 1'b1; bus.acc_mode = 1'b0; bus.base_addr = 11'd400; bus.num_words = 12'd3;
        bus.rd_req = 1'b1; bus.rd_addr = 11'd10;
        #1 chk("start wins", {bus.rd_ready, bus.mem_cen}, 2'b01);
        @(negedge clk);
        bus.start = 1'b0;
        #1 chk("rd while busy", {bus.rd_ready, bus.rd_valid, bus.busy, bus.mem_addr},
               {1'b0, 1'b0, 1'b1, 11'd400});
        lat = -1;
        for (int k = 2; k <= 50; k++) begin
            @(negedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        chk("arb drain latency", lat, 4);
        @(negedge clk);
        #1 chk("held rd granted", {bus.rd_ready, bus.mem_cen, bus.mem_wen, bus.mem_addr},
               {1'b1, 1'b0, 1'b1, 11'd10});
        @(negedge clk);
        bus.rd_req = 1'b0;
        #1 chk("held rd data", {bus.rd_valid, bus.rd_data}, {1'b1, mk(16'd1, 16'd1)});
        @(negedge clk);
        #1 chk("rd_data holds", {bus.rd_valid, bus.rd_data}, {1'b0, mk(16'd1, 16'd1)});

        // Reset during the second word of a drain
        for (int k = 0; k < 4; k++) push(mk(16'd21 + 16'(k), 16'd0));
        @(negedge clk);
        bus.start = 1'b1; bus.acc_mode = 1'b0; bus.base_addr = 11'd500; bus.num_words = 12'd4;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #1 reset = 1'b0;
        #1 chk("mid rst ctrl", {bus.busy, bus.done, bus.ofifo_rd, bus.rd_ready,
                                bus.mem_cen, bus.mem_wen}, 6'b000011);
        chk("mid rst addr", bus.mem_addr, '0);
        @(negedge clk);
        reset = 1'b1;
        ftail = fhead;
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1 if (bus.done || bus.busy) dones++;
        end
        chk("no done after rst", dones, 0);
        host_read(11'd500, rdy, vld, d);
        chk("rst kept word 500", {rdy, vld, d}, {1'b1, 1'b1, mk(16'd21, 16'd0)});
        host_read(11'd501, rdy, vld, d);
        chk("rst untouched 501", {rdy, vld, d}, {1'b1, 1'b1, mk(16'd9, 16'd0)});
        run_drain(1'b0, 11'd500, 2, 16'd31, 16'd1, 16'd0, lat, wr);
        chk("post rst latency", lat, 3);
        chk("post rst writes", wr, 2);
        host_read(11'd501, rdy, vld, d);
        chk("post rst word 501", {rdy, vld, d}, {1'b1, 1'b1, mk(16'd32, 16'd0)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
